// File: rtl/pps_in_timestamper_pkg.sv
// pps_in_timestamper_pkg: PTP time constants, RTC word layout and the
// latency-compensation helper. Macros RTC_SEC/RTC_NS slice an RTC word.
`ifndef PPS_IN_TIMESTAMPER_PKG_SV
`define PPS_IN_TIMESTAMPER_PKG_SV

`define RTC_SEC(t) t[79:32]
`define RTC_NS(t) t[31:0]

package pps_in_timestamper_pkg;

  localparam int RTC_SEC_W = 48;
  localparam int RTC_NS_W  = 32;
  localparam int RTC_W     = 80;

  localparam logic [RTC_NS_W-1:0] NS_PER_SEC =
    32'd1_000_000_000;

  typedef logic [RTC_W-1:0] rtc_t;

  typedef struct packed {
    logic [RTC_SEC_W-1:0] sec;
    logic [RTC_NS_W-1:0]  ns;
  } rtc_f_t;

  // Subtract a ns offset; borrow one second when ns underflows.
  // Seconds wrap modulo 2^48.
  function automatic rtc_t rtc_comp(
    rtc_t        t,
    logic [15:0] c
  );
    rtc_f_t              r;
    logic [RTC_NS_W-1:0] c_ns;
    c_ns  = RTC_NS_W'(c);
    r.sec = `RTC_SEC(t);
    r.ns  = `RTC_NS(t);
    if (r.ns >= c_ns) begin
      r.ns = r.ns - c_ns;
    end else begin
      r.ns  = r.ns + NS_PER_SEC - c_ns;
      r.sec = r.sec - RTC_SEC_W'(1);
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/pps_in_timestamper_if.sv
// pps_in_timestamper_if: timestamp FIFO read port.
// master drives pts_std/pts_vld and takes pts_ack; slave is the reader.
interface pps_in_timestamper_if;
  import pps_in_timestamper_pkg::*;

  rtc_t pts_std;
  logic pts_vld;
  logic pts_ack;

  modport master (
    output pts_std,
    output pts_vld,
    input  pts_ack
  );

  modport slave (
    input  pts_std,
    input  pts_vld,
    output pts_ack
  );

endinterface

// File: rtl/pps_ts_fifo.sv
// pps_ts_fifo: DEPTH x 80 synchronous FIFO. Ports: push_i/din_i,
// pop_i, dout_o (head, 0 when empty), full_o, empty_o.
module pps_ts_fifo
  import pps_in_timestamper_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  rtc_t din_i,
  input  logic pop_i,
  output rtc_t dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  rtc_t          mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0])
           && (wr_q[AW] != rd_q[AW]);
    do_pop  = pop_i && !empty_o;
    // A pop frees the slot this same edge, so push may proceed.
    do_push = push_i && (!full_o || do_pop);
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/pps_in_timestamper.sv
// pps_in_timestamper: syncs pps_i, detects the selected edge, snapshots
// the RTC minus comp_ns_i into a FIFO read through pts (master).
// Other ports: clk, rst_n (sync, low), pps_i, rtc_std_i, cap_en_i,
// edge_sel_i, comp_ns_i, pps_evt_o, ovf_o, ovf_clr_i.
// Optional glitch filter: define PPS_FILTER_EN.
module pps_in_timestamper
  import pps_in_timestamper_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int FILT_CYC    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pps_i,
  input  rtc_t                        rtc_std_i,
  input  logic                        cap_en_i,
  input  logic                        edge_sel_i,
  input  logic [15:0]                 comp_ns_i,
  pps_in_timestamper_if.master        pts,
  output logic                        pps_evt_o,
  output logic                        ovf_o,
  input  logic                        ovf_clr_i
);

  if (SYNC_STAGES < 2 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 ||
      FILT_CYC < 1) begin : g_bad_cfg
    $error("pps_in_timestamper: bad parameters");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pps_s;
  logic                   lvl;
  logic                   prev_q, prev_d;
  logic                   cap_v_q, cap_v_d;
  rtc_t                   snap_q, snap_d;
  logic [15:0]            comp_q, comp_d;
  logic                   ovf_q, ovf_d;
  logic                   hit;
  logic                   full;
  logic                   empty;
  logic                   drop;
  rtc_t                   ts_c;
  rtc_t                   head;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pps_i};
    pps_s  = sync_q[SYNC_STAGES-1];
  end

`ifdef PPS_FILTER_EN
  localparam int FW = $clog2(FILT_CYC + 1);

  logic          flvl_q, flvl_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Count consecutive samples differing from the accepted level;
  // accept the new level on the FILT_CYC-th one.
  always_comb begin
    flvl_d = flvl_q;
    fcnt_d = '0;
    if (pps_s != flvl_q) begin
      if (fcnt_q == FW'(FILT_CYC - 1)) begin
        flvl_d = pps_s;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flvl_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      flvl_q <= flvl_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl = flvl_q;
`else
  assign lvl = pps_s;
`endif

  always_comb begin
    hit = 1'b0;
    unique case (1'b1)
      edge_sel_i:  hit = !lvl && prev_q;
      !edge_sel_i: hit = lvl && !prev_q;
    endcase
    hit     = hit && cap_en_i;
    prev_d  = lvl;
    cap_v_d = hit;
    snap_d  = hit ? rtc_std_i : snap_q;
    comp_d  = hit ? comp_ns_i : comp_q;
    ts_c    = rtc_comp(snap_q, comp_q);
    // Full implies non-empty, so an ack here is a real pop.
    drop    = cap_v_q && full && !pts.pts_ack;
    ovf_d   = (ovf_q && !ovf_clr_i) || drop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      cap_v_q <= 1'b0;
      snap_q  <= '0;
      comp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cap_v_q <= cap_v_d;
      snap_q  <= snap_d;
      comp_q  <= comp_d;
      ovf_q   <= ovf_d;
    end
  end

  pps_ts_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cap_v_q),
    .din_i   (ts_c),
    .pop_i   (pts.pts_ack),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign pts.pts_std = head;
  assign pts.pts_vld = !empty;
  assign pps_evt_o   = cap_v_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pps_in_timestamper.sv
// tb_pps_in_timestamper: vector table, corner sequences and random
// pulses checked against an arithmetic timestamp model.
module tb_pps_in_timestamper;

  localparam int SYNC  = 2;
  localparam int DEPTH = 4;
  localparam int FILT  = 4;
`ifdef PPS_FILTER_EN
  localparam int LAT = SYNC + FILT + 2;
`else
  localparam int LAT = SYNC + 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        pps_i;
  logic [79:0] rtc;
  logic        cap_en;
  logic        edge_sel;
  logic [15:0] comp;
  logic        evt;
  logic        ovf;
  logic        ovf_clr;

  int total;
  int bad;
  int evt_cnt;

  pps_in_timestamper_if pif ();

  pps_in_timestamper #(
    .SYNC_STAGES (SYNC),
    .DEPTH       (DEPTH),
    .FILT_CYC    (FILT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pps_i      (pps_i),
    .rtc_std_i  (rtc),
    .cap_en_i   (cap_en),
    .edge_sel_i (edge_sel),
    .comp_ns_i  (comp),
    .pts        (pif),
    .pps_evt_o  (evt),
    .ovf_o      (ovf),
    .ovf_clr_i  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [47:0] sec;
    logic [31:0] ns;
    logic [15:0] comp;
    logic [79:0] exp;
  } vec_t;

  vec_t        vecs [7];
  logic [79:0] q [$];
  logic        ovf_m;

  task automatic tick();
    @(posedge clk);
    #1;
    if (evt) evt_cnt++;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(string name, logic [79:0] act,
                     logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Time as a single ns count modulo 2^48 seconds.
  function automatic logic [79:0] exp_ts(logic [47:0] s,
                                         logic [31:0] n,
                                         logic [15:0] c);
    logic [127:0] ns1;
    logic [127:0] span;
    logic [127:0] t;
    ns1  = 128'd1_000_000_000;
    span = (128'd1 << 48) * ns1;
    t = ({80'd0, s} * ns1 + {96'd0, n} + span
         - {112'd0, c}) % span;
    return {48'(t / ns1), 32'(t % ns1)};
  endfunction

  task automatic pop_chk(string name, logic [79:0] exp);
    chk({name, "_vld"}, {79'd0, pif.pts_vld}, 80'd1);
    chk({name, "_std"}, pif.pts_std, exp);
    pif.pts_ack = 1'b1;
    tick();
    pif.pts_ack = 1'b0;
  endtask

  task automatic pulse(int h);
    pps_i = 1'b1;
    ticks(h);
    pps_i = 1'b0;
    ticks(LAT + 2);
  endtask

  initial begin
    logic [63:0] r64;
    logic [47:0] s;
    logic [31:0] n;
    logic [15:0] c;
    logic        sel;
    logic        en;
    int          h;
    int          e0;

    vecs[0] = '{1'b0, 48'h1234_5678, 32'd500, 16'd24,
                {48'h1234_5678, 32'd476}};
    vecs[1] = '{1'b0, 48'h2222_3333, 32'd10, 16'd24,
                {48'h2222_3332, 32'd999_999_986}};
    vecs[2] = '{1'b0, 48'h0, 32'd10, 16'd24,
                {48'hFFFF_FFFF_FFFF, 32'd999_999_986}};
    vecs[3] = '{1'b1, 48'hAB, 32'd24, 16'd24,
                {48'hAB, 32'd0}};
    vecs[4] = '{1'b1, 48'hAB, 32'd23, 16'd24,
                {48'hAA, 32'd999_999_999}};
    vecs[5] = '{1'b1, 48'h1, 32'd999_999_999, 16'd0,
                {48'h1, 32'd999_999_999}};
    vecs[6] = '{1'b0, 48'h5, 32'd0, 16'hFFFF,
                {48'h4, 32'd999_934_465}};

    total = 0;
    bad = 0;
    evt_cnt = 0;
    rst_n = 1'b0;
    pps_i = 1'b0;
    rtc = '0;
    cap_en = 1'b0;
    edge_sel = 1'b0;
    comp = '0;
    ovf_clr = 1'b0;
    pif.pts_ack = 1'b0;

    ticks(3);
    chk("rst_vld", {79'd0, pif.pts_vld}, 80'd0);
    chk("rst_std", pif.pts_std, 80'd0);
    chk("rst_evt", {79'd0, evt}, 80'd0);
    chk("rst_ovf", {79'd0, ovf}, 80'd0);
    rst_n = 1'b1;
    ticks(2);

    // Vector table: latency, compensation, edge select.
    cap_en = 1'b1;
    for (int v = 0; v < 7; v++) begin
      rtc = {vecs[v].sec, vecs[v].ns};
      comp = vecs[v].comp;
      edge_sel = vecs[v].sel;
      pps_i = vecs[v].sel;
      ticks(LAT + 2);
      chk($sformatf("v%0d_pre", v),
          {79'd0, pif.pts_vld}, 80'd0);
      pps_i = ~vecs[v].sel;
      ticks(LAT - 1);
      chk($sformatf("v%0d_evt", v), {79'd0, evt}, 80'd1);
      chk($sformatf("v%0d_early", v),
          {79'd0, pif.pts_vld}, 80'd0);
      tick();
      chk($sformatf("v%0d_evt1", v), {79'd0, evt}, 80'd0);
      pps_i = 1'b0;
      ticks(LAT + 2);
      pop_chk($sformatf("v%0d", v), vecs[v].exp);
      chk($sformatf("v%0d_empty", v),
          {79'd0, pif.pts_vld}, 80'd0);
    end
    edge_sel = 1'b0;

    // Ack on empty FIFO is ignored.
    pif.pts_ack = 1'b1;
    tick();
    pif.pts_ack = 1'b0;
    chk("ack_empty", {79'd0, pif.pts_vld}, 80'd0);

    // Overflow: five edges, no ack.
    comp = 16'd0;
    evt_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      rtc = {48'h100, 32'(i)};
      pulse(1 + (FILT > 0 ? 0 : 0) + LAT - SYNC - 2);
    end
    chk("ovf_set", {79'd0, ovf}, 80'd1);
    chk("ovf_evts", 80'(evt_cnt), 80'd5);
    // Clear and new overflow in one cycle: set wins.
    rtc = {48'h100, 32'd5};
    pps_i = 1'b1;
    ticks(LAT - 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_set_wins", {79'd0, ovf}, 80'd1);
    pps_i = 1'b0;
    ticks(LAT + 2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", {79'd0, ovf}, 80'd0);
    for (int i = 0; i < 4; i++)
      pop_chk($sformatf("ovf_keep%0d", i),
              {48'h100, 32'(i)});
    chk("ovf_drained", {79'd0, pif.pts_vld}, 80'd0);

    // Full with simultaneous pop: no overflow.
    for (int i = 10; i < 14; i++) begin
      rtc = {48'h200, 32'(i)};
      pulse(LAT - SYNC - 1);
    end
    rtc = {48'h200, 32'd14};
    pps_i = 1'b1;
    ticks(LAT - 1);
    chk("fullpop_evt", {79'd0, evt}, 80'd1);
    pif.pts_ack = 1'b1;
    tick();
    pif.pts_ack = 1'b0;
    pps_i = 1'b0;
    chk("fullpop_ovf", {79'd0, ovf}, 80'd0);
    ticks(LAT + 2);
    for (int i = 11; i < 15; i++)
      pop_chk($sformatf("fullpop%0d", i),
              {48'h200, 32'(i)});
    chk("fullpop_drained", {79'd0, pif.pts_vld}, 80'd0);

    // Capture enable.
    rtc = {48'h300, 32'd77};
    cap_en = 1'b0;
    e0 = evt_cnt;
    pulse(LAT - SYNC - 1);
    chk("capen0_vld", {79'd0, pif.pts_vld}, 80'd0);
    chk("capen0_evt", 80'(evt_cnt - e0), 80'd0);
    cap_en = 1'b1;
    pps_i = 1'b1;
    ticks(LAT - 1);
    cap_en = 1'b0;
    tick();
    pps_i = 1'b0;
    ticks(LAT + 2);
    pop_chk("capen_late", {48'h300, 32'd77});
    cap_en = 1'b1;

`ifdef PPS_FILTER_EN
    rtc = {48'h400, 32'd9};
    e0 = evt_cnt;
    pulse(2);
    chk("glitch_vld", {79'd0, pif.pts_vld}, 80'd0);
    chk("glitch_evt", 80'(evt_cnt - e0), 80'd0);
    pulse(10);
    chk("pulse10_evt", 80'(evt_cnt - e0), 80'd1);
    pop_chk("pulse10", {48'h400, 32'd9});
`else
    rtc = {48'h400, 32'd9};
    e0 = evt_cnt;
    pulse(1);
    chk("pulse1_evt", 80'(evt_cnt - e0), 80'd1);
    pop_chk("pulse1", {48'h400, 32'd9});
`endif

    // Reset with full FIFO, ovf set and a capture in flight.
    for (int i = 0; i < 5; i++) begin
      rtc = {48'h500, 32'(i)};
      pulse(LAT - SYNC - 1);
    end
    chk("prerst_ovf", {79'd0, ovf}, 80'd1);
    pps_i = 1'b1;
    ticks(LAT - 1);
    rst_n = 1'b0;
    pps_i = 1'b0;
    tick();
    chk("midrst_vld", {79'd0, pif.pts_vld}, 80'd0);
    chk("midrst_ovf", {79'd0, ovf}, 80'd0);
    chk("midrst_std", pif.pts_std, 80'd0);
    rst_n = 1'b1;
    ticks(LAT + 4);
    chk("postrst_vld", {79'd0, pif.pts_vld}, 80'd0);
    chk("postrst_evt", {79'd0, evt}, 80'd0);

    // Random pulses against the queue model.
    q.delete();
    ovf_m = 1'b0;
    for (int it = 0; it < 60; it++) begin
      r64 = {$urandom(), $urandom()};
      s = r64[47:0];
      n = $urandom() % 32'd1_000_000_000;
      c = 16'($urandom());
      sel = 1'($urandom());
      en = ($urandom() % 4) != 0;
`ifdef PPS_FILTER_EN
      h = $urandom_range(FILT + 6, FILT + 1);
`else
      h = $urandom_range(6, 1);
`endif
      rtc = {s, n};
      comp = c;
      edge_sel = sel;
      cap_en = en;
      pulse(h);
      if (en) begin
        if (q.size() == DEPTH) ovf_m = 1'b1;
        else q.push_back(exp_ts(s, n, c));
      end
      if (($urandom() % 3) == 0 || it == 59) begin
        chk("rnd_ovf", {79'd0, ovf}, {79'd0, ovf_m});
        for (int k = 0; k < q.size(); k++)
          pop_chk($sformatf("rnd%0d_%0d", it, k), q[k]);
        chk("rnd_empty", {79'd0, pif.pts_vld}, 80'd0);
        q.delete();
        ovf_m = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pps_in_timestamper.md
Name: pps_in_timestamper

Overview:
- Receiver end of the PPS interface: samples the asynchronous pps_i line and detects the selected edge.
- On each edge, snapshots the 80-bit RTC time, subtracts a programmable synchronizer/latency compensation and queues the result in a small FIFO.
- The RTC register block reads and pops the FIFO.
- Sits in the rtc unit next to the RTC counter; its output is the pps-input timestamp that software compares against the locally generated pps_o.

Parameters:
SYNC_STAGES, 2, synchronizer flops on pps_i (min 2)
DEPTH, 4, timestamp FIFO entries (power of 2, min 2)
FILT_CYC, 4, consecutive stable samples required before a level change is accepted (only with PPS_FILTER_EN)

Ports:
clk  in  1  system clock; one clock domain
rst_n  in  1  reset, synchronous and active-low
pps_i  in  1  asynchronous pps input
rtc_std_i  in  80  current RTC: [79:32] seconds, [31:0] nanoseconds (0..999_999_999)
cap_en_i  in  1  capture enable
edge_sel_i  in  1  0 = rising edge, 1 = falling edge
comp_ns_i  in  16  latency compensation in ns, subtracted from the snapshot
pts_std_o  out  80  FIFO head timestamp
pts_vld_o  out  1  FIFO not empty
pts_ack_i  in  1  pop head; ignored when pts_vld_o=0
pps_evt_o  out  1  one-cycle pulse when a timestamp is written
ovf_o  out  1  sticky overflow flag
ovf_clr_i  in  1  clears ovf_o

Behaviour:
- Reset (rst_n=0 at a clk edge): clears the sync chain, filter, edge history, pipeline and FIFO pointers.
  - pts_std_o=0, pts_vld_o=0, pps_evt_o=0, ovf_o=0.
  - A reset mid-capture discards in-flight data.
- Sync: SYNC_STAGES flops produce pps_s.
- Filter: the level register follows pps_s only after FILT_CYC consecutive equal samples. Without PPS_FILTER_EN, the level register equals pps_s.
- Edge detection: compares the level register with its previous value.
  - Rising edge: 0->1. Falling edge: 1->0, as chosen by edge_sel_i sampled in the detect cycle.
  - The edge counts only if cap_en_i=1 in that cycle.
  - Deasserting cap_en_i does not cancel a capture already in the pipeline.
- Stage 1, edge cycle: latch rtc_std_i and comp_ns_i; set cap_v.
- Stage 2, next cycle: compensation.
  - If ns >= comp: ns' = ns - comp; sec unchanged.
  - Else: ns' = ns + 1_000_000_000 - comp; sec' = sec - 1, with modulo-2^48 wrap (0 -> 48'hFFFF_FFFF_FFFF).
  - Write the result to the FIFO; pps_evt_o pulses in the same cycle.
  - pts_vld_o rises the cycle after the write: 2 cycles after the filtered edge.
- FIFO:
  - pts_std_o always shows the head.
  - pts_ack_i with pts_vld_o=1 pops at the clk edge.
- Full:
  - A write when full with no pop is dropped. Existing entries are kept, ovf_o sets, and pps_evt_o still pulses.
  - A write and pop in the same cycle when full both succeed; ovf_o is not set.
- Empty: simultaneous write and pop is not possible, since the pop is ignored.
- ovf_o:
  - Stays set until ovf_clr_i.
  - If clear and a new overflow occur in the same cycle, set wins.
- Minimum edge spacing is unconstrained. Back-to-back edges are each captured in order.

Optional Feature:
- Macro: PPS_FILTER_EN.
- Defined: the glitch filter is present. Latency from a clean pps_i edge to pts_vld_o is SYNC_STAGES+FILT_CYC+2 cycles, and pulses shorter than FILT_CYC cycles are ignored.
- Undefined: no filter logic, FILT_CYC is unused, and latency is SYNC_STAGES+2 cycles.
- Software sets comp_ns_i to match the latency of whichever configuration is built.

Decomposition:
- Shared ptpv2 package/defines:
  - NS_PER_SEC = 32'd1_000_000_000.
  - RTC_SEC_W = 48, RTC_NS_W = 32, RTC_W = 80.
  - Field-slice macros for sec/ns.
- Sub-module: pps_ts_fifo, a synchronous DEPTH x 80 FIFO with push/pop/full/empty and a simultaneous push-pop-when-full rule.
- Edge detect and compensation stay in the top module.

Test Plan:
- Basic rising edge: edge_sel=0, rtc={48'h1234_5678, 32'd500}, comp=24. Result: pts_std_o={48'h1234_5678, 32'd476}, pps_evt_o pulses once, pts_vld_o 2 cycles after the filtered edge.
- Borrow: ns=10, comp=24, sec=48'h2222_3333. Result: {48'h2222_3332, 32'd999_999_986}. With sec=0: sec'=48'hFFFF_FFFF_FFFF.
- Overflow: DEPTH=4, five edges, no ack. Result: the first four timestamps are retained in order and ovf_o=1. An ack during the fifth write when full instead results in no overflow. ovf_clr_i clears ovf_o.
- Edge select/enable: edge_sel=1 captures only on the falling edge. cap_en_i=0 gives no capture. cap_en_i dropped one cycle after the edge still produces the entry.
- Filter (PPS_FILTER_EN, FILT_CYC=4): a 2-cycle high glitch gives no capture; a 10-cycle pulse gives exactly one capture.
- Reset mid-operation: rst_n low with 2 entries queued and a capture in stage 1. Result: pts_vld_o=0 and ovf_o=0 next cycle, and no stale entry appears afterward.
